// File: rtl/array_serializer.sv
// ============================================================================
//  Module   : array_serializer
//  Brief    : Captures a ROWS x COLS array of WIDTH-bit words in one input
//             handshake and streams it out LANES words per beat over a
//             valid/ready interface with first/last frame markers and a
//             beat index.
//  Options  : ARRAY_SER_COL_MAJOR_EN - when defined, elements are streamed
//             in column-major order (k = c*ROWS + r) instead of row-major
//             (k = r*COLS + c). Input bit layout and timing are unchanged.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module array_serializer #(
    parameter int ROWS  = 16,
    parameter int COLS  = 9,
    parameter int WIDTH = 32,
    parameter int LANES = 3,
    // Derived values; not intended to be overridden.
    parameter int N     = ROWS * COLS,
    parameter int BEATS = N / LANES,
    parameter int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N*WIDTH-1:0]       i_bus_in,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [LANES*WIDTH-1:0]   o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_first,
    output logic                     o_last,
    output logic [BW-1:0]            o_beat_idx
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam int            BEAT_BITS = LANES * WIDTH;
    // Beat table is padded to a power of two so any counter value indexes it.
    localparam int            NB        = 1 << BW;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    // An array that cannot be split evenly into beats is a configuration bug.
    if ((N % LANES) != 0) begin : g_lanes_check
        $error("array_serializer: ROWS*COLS must be divisible by LANES");
    end

    logic [0:0]           state_q, state_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic [N*WIDTH-1:0]   cap_q, cap_d;
    logic [N*WIDTH-1:0]   ordered;
    logic [BEAT_BITS-1:0] beats [NB];
    logic                 is_last;
    logic                 take_out;
    logic                 take_in;

    // The capture register holds elements already in stream order, so the
    // traversal choice is pure wiring and each beat is a contiguous slice.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
`ifdef ARRAY_SER_COL_MAJOR_EN
            assign ordered[(c*ROWS + r)*WIDTH +: WIDTH] = i_bus_in[(r*COLS + c)*WIDTH +: WIDTH];
`else
            assign ordered[(r*COLS + c)*WIDTH +: WIDTH] = i_bus_in[(r*COLS + c)*WIDTH +: WIDTH];
`endif
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_beat
        if (b < BEATS) begin : g_used
            assign beats[b] = cap_q[b*BEAT_BITS +: BEAT_BITS];
        end else begin : g_pad
            assign beats[b] = '0;
        end
    end

    assign is_last    = (cnt_q == LAST_BEAT);
    assign o_valid    = (state_q == SEND);
    assign o_first    = o_valid && (cnt_q == '0);
    assign o_last     = o_valid && is_last;
    assign o_beat_idx = cnt_q;
    assign o_data     = o_valid ? beats[cnt_q] : '0;

    // Accepting the final beat frees the register in the same cycle, which
    // lets a waiting array follow without a bubble (i_ready -> o_ready path).
    assign o_ready  = !i_rst && ((state_q == IDLE) || (o_valid && is_last && i_ready));
    assign take_out = o_valid && i_ready;
    assign take_in  = i_valid && o_ready;

    // Next-state: advance on an accepted beat; a capture overrides the return to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        if (take_out) begin
            if (is_last) begin
                cnt_d   = '0;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + BW'(1);
            end
        end
        if (take_in) begin
            cap_d   = ordered;
            cnt_d   = '0;
            state_d = SEND;
        end
    end

    // State, beat counter and capture register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

endmodule

`default_nettype wire
